pool_mul_pipe: RTL

- Parametrised, pipelined multiply-scale unit for the Pool datapath.
- Used for average-pool scaling (window sum × reciprocal, then right shift) and general MAC pre-products.
- Generalises the fixed 16×8 unsigned pipelined multiplier with the following additions:
  - configurable operand widths and signedness;
  - configurable pipeline depth;
  - post-multiply rounding shift and optional saturation with an overflow flag;
  - per-stage valid/ready flow control with bubble collapsing.

---
 rtl/pool_mul_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pool_mul_pipe.sv
// Pipelined multiply-scale unit: configurable-signedness product, rounding shift and
// optional saturation, with per-stage valid/ready flow control and bubble collapsing.
module pool_mul_pipe #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned P_WIDTH   = 16,
  parameter bit          A_SIGNED  = 1'b0,
  parameter bit          B_SIGNED  = 1'b0,
  parameter int unsigned SHIFT     = 0,
  parameter bit          ROUND     = 1'b0,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned NUM_STAGE = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ce,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [B_WIDTH-1:0] i_b,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [P_WIDTH-1:0] o_p,
  output logic               o_ovf
);

  localparam int unsigned FW  = A_WIDTH + B_WIDTH + 1;
  // Internal width also covers the P_WIDTH range constants.
  localparam int unsigned W   = (FW > P_WIDTH + 1) ? FW : P_WIDTH + 1;
  localparam int          NS  = int'(NUM_STAGE);
  localparam int unsigned SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam bit          P_SIGNED = A_SIGNED | B_SIGNED;

  localparam logic signed [W-1:0] RND   = (ROUND && SHIFT > 0) ? (W'(1) << SH1) : '0;
  localparam logic signed [W-1:0] MAX_S = {{(W-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_S = {{(W-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_U = {{(W-P_WIDTH){1'b0}}, {P_WIDTH{1'b1}}};

  logic [NUM_STAGE-1:0] r_v;
  logic [NUM_STAGE-1:0] w_v_in;
  logic [NUM_STAGE-1:0] w_rdy;
  logic                 w_full_tail;

  logic [A_WIDTH-1:0]   r_a;
  logic [B_WIDTH-1:0]   r_b;
  logic signed [W-1:0]  w_a_ext;
  logic signed [W-1:0]  w_b_ext;
  logic signed [W-1:0]  w_prod;
  logic signed [W-1:0]  w_tail;
  logic signed [W-1:0]  w_rnd;
  logic signed [W-1:0]  w_sh;
  logic [P_WIDTH-1:0]   w_res;
  logic                 w_ovf;
  logic [P_WIDTH-1:0]   r_p;
  logic                 r_ovf;

  // A stage may load unless it and every stage downstream of it are full with the
  // output stalled; this is the ready chain unrolled, so empty stages always fill.
  always_comb begin
    w_full_tail = !i_out_ready;
    w_rdy       = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      w_full_tail = w_full_tail && r_v[k];
      w_rdy[k]    = i_ce && !w_full_tail;
    end
  end

  assign w_v_in      = {r_v[NUM_STAGE-2:0], i_in_valid};
  assign o_in_ready  = w_rdy[0];
  assign o_out_valid = r_v[NUM_STAGE-1];
  assign o_p         = r_p;
  assign o_ovf       = r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (w_rdy[k]) r_v[k] <= w_v_in[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rdy[0] && i_in_valid) begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  assign w_a_ext = {{(W-A_WIDTH){A_SIGNED ? r_a[A_WIDTH-1] : 1'b0}}, r_a};
  assign w_b_ext = {{(W-B_WIDTH){B_SIGNED ? r_b[B_WIDTH-1] : 1'b0}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  if (NUM_STAGE > 2) begin : g_prod
    logic signed [W-1:0] r_prod [1:NUM_STAGE-2];

    always_ff @(posedge i_clk) begin
      if (w_rdy[1] && r_v[0]) r_prod[1] <= w_prod;
      for (int k = 2; k <= NS - 2; k++) begin
        if (w_rdy[k] && r_v[k-1]) r_prod[k] <= r_prod[k-1];
      end
    end

    assign w_tail = r_prod[NUM_STAGE-2];
  end else begin : g_noprod
    // Two-stage pipeline: product and scaling share the output stage.
    assign w_tail = w_prod;
  end

  assign w_rnd = w_tail + RND;
  assign w_sh  = w_rnd >>> SHIFT;

  always_comb begin
    w_ovf = 1'b0;
    w_res = w_sh[P_WIDTH-1:0];
    if (P_SIGNED) begin
      if (w_sh > MAX_S) begin
        w_ovf = 1'b1;
        if (SATURATE) w_res = MAX_S[P_WIDTH-1:0];
      end else if (w_sh < MIN_S) begin
        w_ovf = 1'b1;
        if (SATURATE) w_res = MIN_S[P_WIDTH-1:0];
      end
    end else if (w_sh > MAX_U) begin
      w_ovf = 1'b1;
      if (SATURATE) w_res = MAX_U[P_WIDTH-1:0];
    end
  end

  // Output register only loads real items, so p/ovf hold through stalls and bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p   <= '0;
      r_ovf <= 1'b0;
    end else if (w_rdy[NUM_STAGE-1] && r_v[NUM_STAGE-2]) begin
      r_p   <= w_res;
      r_ovf <= w_ovf;
    end
  end

endmodule
